// File: rtl/shape_sequencer_if.sv
// Command and raster-side signal bundle for the shape sequencer.
// The master side is the opcode decoder plus raster engine; the slave side is the sequencer.
interface shape_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_shape;
  logic [15:0] cmd_color;
  logic [75:0] cmd_opdata;
  logic [75:0] op_opdata;
  logic [3:0]  output_sel;
  logic [15:0] draw_color;
  logic        draw_start;
  logic        draw_circle;
  logic        draw_done;
  logic [1:0]  seg_idx;
  logic        busy;
  logic        shape_done;
  logic        err;

  modport master (
    output cmd_valid, cmd_shape, cmd_color, cmd_opdata, draw_done,
    input  cmd_ready, op_opdata, output_sel, draw_color, draw_start,
           draw_circle, seg_idx, busy, shape_done, err
  );

  modport slave (
    input  cmd_valid, cmd_shape, cmd_color, cmd_opdata, draw_done,
    output cmd_ready, op_opdata, output_sel, draw_color, draw_start,
           draw_circle, seg_idx, busy, shape_done, err
  );
endinterface

// File: rtl/shape_sequencer.sv
// Shape sequencer: accepts one draw command, walks the location splitter
// through each segment of the shape and hands every segment to the raster
// engine with a start/done handshake, guarded by a per-segment watchdog.
// All outputs are registered; they are computed from the next state.
module shape_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic              clk,
  input  logic              rst,
  shape_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]    SHAPE_LINE   = 2'b00;
  localparam logic [1:0]    SHAPE_TRI    = 2'b01;
  localparam logic [1:0]    SHAPE_CIRCLE = 2'b10;
  localparam logic [3:0]    SEL_IDLE     = 4'b1111;
  localparam logic [TO_W-1:0] WD_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] WD_MAX     = {TO_W{1'b1}};

  // Index of the final segment for a shape.
  function automatic logic [1:0] last_seg(input logic [1:0] shape);
    logic [1:0] last;
    case (shape)
      SHAPE_TRI: last = 2'd2;
      default:   last = 2'd0;
    endcase
    return last;
  endfunction

  // Splitter select for a given shape and segment index.
  function automatic logic [3:0] seg_sel(input logic [1:0] shape, input logic [1:0] idx);
    logic [3:0] sel;
    case (shape)
      SHAPE_LINE:   sel = 4'b0000;
      SHAPE_TRI:    sel = {2'b00, idx} + 4'd1;
      SHAPE_CIRCLE: sel = 4'b0100;
      default:      sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

  state_t          state_r, state_next_s;
  logic [1:0]      shape_r, shape_next_s;
  logic [1:0]      seg_idx_r, seg_next_s;
  logic [TO_W-1:0] wd_r;
  logic            accept_s, illegal_s, timeout_s;

  logic [75:0]     op_opdata_r;
  logic [15:0]     draw_color_r;
  logic [3:0]      output_sel_r;
  logic            draw_start_r, draw_circle_r, cmd_ready_r, busy_r;
  logic            shape_done_r, err_r;

  // Next-state and per-cycle decisions of the command FSM.
  always_comb begin
    state_next_s = state_r;
    shape_next_s = shape_r;
    seg_next_s   = seg_idx_r;
    accept_s     = 1'b0;
    illegal_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_shape == 2'b11) begin
            illegal_s = 1'b1;
          end else begin
            accept_s     = 1'b1;
            shape_next_s = bus.cmd_shape;
            seg_next_s   = 2'd0;
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.draw_done) begin
          if (seg_idx_r < last_seg(shape_r)) begin
            seg_next_s   = seg_idx_r + 2'd1;
            state_next_s = ST_ISSUE;
          end else begin
            state_next_s = ST_DONE;
          end
        end else if (wd_r >= WD_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, command capture, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      shape_r       <= 2'b00;
      seg_idx_r     <= 2'd0;
      wd_r          <= '0;
      op_opdata_r   <= 76'd0;
      draw_color_r  <= 16'd0;
      output_sel_r  <= SEL_IDLE;
      draw_start_r  <= 1'b0;
      draw_circle_r <= 1'b0;
      cmd_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      shape_done_r  <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      shape_r   <= shape_next_s;
      seg_idx_r <= seg_next_s;

      if (accept_s) begin
        op_opdata_r  <= bus.cmd_opdata;
        draw_color_r <= bus.cmd_color;
      end else begin
        op_opdata_r  <= op_opdata_r;
        draw_color_r <= draw_color_r;
      end

      // Watchdog only runs while waiting; it saturates instead of wrapping.
      if (state_r == ST_WAIT) begin
        if (wd_r != WD_MAX) begin
          wd_r <= wd_r + TO_W'(1);
        end else begin
          wd_r <= wd_r;
        end
      end else begin
        wd_r <= '0;
      end

      // Segment select and circle flag are loaded on issue and held while waiting.
      if (state_next_s == ST_ISSUE) begin
        output_sel_r  <= seg_sel(shape_next_s, seg_next_s);
        draw_circle_r <= (shape_next_s == SHAPE_CIRCLE);
      end else if (state_next_s == ST_WAIT) begin
        output_sel_r  <= output_sel_r;
        draw_circle_r <= draw_circle_r;
      end else begin
        output_sel_r  <= SEL_IDLE;
        draw_circle_r <= 1'b0;
      end

      draw_start_r <= (state_next_s == ST_ISSUE);
      cmd_ready_r  <= (state_next_s == ST_IDLE);
      busy_r       <= (state_next_s != ST_IDLE);
      shape_done_r <= (state_next_s == ST_DONE);
      err_r        <= illegal_s | timeout_s;
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.op_opdata   = op_opdata_r;
  assign bus.output_sel  = output_sel_r;
  assign bus.draw_color  = draw_color_r;
  assign bus.draw_start  = draw_start_r;
  assign bus.draw_circle = draw_circle_r;
  assign bus.seg_idx     = seg_idx_r;
  assign bus.busy        = busy_r;
  assign bus.shape_done  = shape_done_r;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_shape_sequencer.sv
// Directed scoreboard bench for shape_sequencer (watchdog shortened to 8 cycles).
module tb_shape_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   start_cnt;
  int   sd_cnt;
  logic [6:0] seg_q[$];   // {output_sel, draw_circle, seg_idx} per expected draw_start
  logic [1:0] end_q[$];   // {shape_done, err} per expected terminating pulse

  shape_sequencer_if bus();

  shape_sequencer #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] shape, input logic [15:0] col, input logic [75:0] od);
    bus.cmd_valid  = 1'b1;
    bus.cmd_shape  = shape;
    bus.cmd_color  = col;
    bus.cmd_opdata = od;
  endtask

  task automatic wait_start(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus.draw_start === 1'b1) found = 1'b1;
      else step(1);
    end
    if (!found) chk("start_wait", bus.draw_start, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  bus.cmd_ready,   1'b1);
    chk({tag, "_sel"},    bus.output_sel,  4'b1111);
    chk({tag, "_opdata"}, bus.op_opdata,   76'd0);
    chk({tag, "_color"},  bus.draw_color,  16'd0);
    chk({tag, "_seg"},    bus.seg_idx,     2'd0);
    chk({tag, "_busy"},   bus.busy,        1'b0);
    chk({tag, "_start"},  bus.draw_start,  1'b0);
    chk({tag, "_circle"}, bus.draw_circle, 1'b0);
    chk({tag, "_sdone"},  bus.shape_done,  1'b0);
    chk({tag, "_err"},    bus.err,         1'b0);
  endtask

  // Scoreboard: pop expectations whenever the DUT starts a segment or ends a command.
  always @(negedge clk) begin
    if (bus.draw_start === 1'b1) begin
      start_cnt++;
      if (seg_q.size() == 0) begin
        chk("unexpected_start", bus.draw_start, 1'b0);
      end else begin
        logic [6:0] e;
        e = seg_q.pop_front();
        chk("seg_sel",    bus.output_sel,  e[6:3]);
        chk("seg_circle", bus.draw_circle, e[2]);
        chk("seg_idx",    bus.seg_idx,     e[1:0]);
      end
    end
    if (bus.shape_done === 1'b1 || bus.err === 1'b1) begin
      if (bus.shape_done === 1'b1) sd_cnt++;
      if (end_q.size() == 0) chk("unexpected_end", {bus.shape_done, bus.err}, 2'b00);
      else chk("end_kind", {bus.shape_done, bus.err}, end_q.pop_front());
    end
  end

  initial begin
    logic [75:0] od_line, od_tri, od_circ, od_ill, od_wd, od_rst, od_l2;
    int st0, sd0;
    checks = 0; errors = 0; start_cnt = 0; sd_cnt = 0;
    od_line = {19'h12345, 19'h00ABC, 19'h00000, 19'h00000};
    od_tri  = {19'h11111, 19'h22222, 19'h33333, 19'h04444};
    od_circ = {19'h0A0A0, 19'h00050, 19'h00000, 19'h7FFFF};
    od_ill  = {19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF};
    od_wd   = {19'h01234, 19'h05678, 19'h09ABC, 19'h00000};
    od_rst  = {19'h3C3C3, 19'h1E1E1, 19'h0F0F0, 19'h00001};
    od_l2   = {19'h00001, 19'h00002, 19'h00000, 19'h00000};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_shape = 2'b00; bus.cmd_color = 16'd0;
    bus.cmd_opdata = 76'd0; bus.draw_done = 1'b0;
    step(2);
    chk_reset_vals("por");
    rst = 1'b0;

    // Line: start in cycle 1, done in cycle 3, shape_done in 4, ready in 5.
    step(1);
    send(2'b00, 16'hF800, od_line);
    seg_q.push_back({4'b0000, 1'b0, 2'd0});
    end_q.push_back(2'b10);
    step(1);
    bus.cmd_valid = 1'b0;
    chk("line_start", bus.draw_start, 1'b1);
    chk("line_opdata", bus.op_opdata, od_line);
    chk("line_color", bus.draw_color, 16'hF800);
    chk("line_busy", bus.busy, 1'b1);
    chk("line_ready", bus.cmd_ready, 1'b0);
    step(2);
    chk("line_sd_early", bus.shape_done, 1'b0);
    bus.draw_done = 1'b1;
    step(1);
    bus.draw_done = 1'b0;
    chk("line_sd", bus.shape_done, 1'b1);
    chk("line_sel_idle", bus.output_sel, 4'b1111);
    step(1);
    chk("line_ready_after", bus.cmd_ready, 1'b1);
    chk("line_busy_after", bus.busy, 1'b0);
    chk("line_opdata_hold", bus.op_opdata, od_line);

    // Triangle: done two cycles after each start.
    st0 = start_cnt; sd0 = sd_cnt;
    send(2'b01, 16'h07E0, od_tri);
    seg_q.push_back({4'b0001, 1'b0, 2'd0});
    seg_q.push_back({4'b0010, 1'b0, 2'd1});
    seg_q.push_back({4'b0011, 1'b0, 2'd2});
    end_q.push_back(2'b10);
    step(1);
    bus.cmd_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_start(10);
      step(2);
      bus.draw_done = 1'b1;
      step(1);
      bus.draw_done = 1'b0;
    end
    chk("tri_sd", bus.shape_done, 1'b1);
    step(3);
    chk("tri_sd_count", sd_cnt - sd0, 1);
    chk("tri_start_count", start_cnt - st0, 3);

    // Circle: single centre/radius segment.
    send(2'b10, 16'h001F, od_circ);
    seg_q.push_back({4'b0100, 1'b1, 2'd0});
    end_q.push_back(2'b10);
    step(1);
    bus.cmd_valid = 1'b0;
    wait_start(5);
    chk("circ_flag", bus.draw_circle, 1'b1);
    step(1);
    chk("circ_hold_sel", bus.output_sel, 4'b0100);
    bus.draw_done = 1'b1;
    step(1);
    bus.draw_done = 1'b0;
    chk("circ_sd", bus.shape_done, 1'b1);
    step(1);

    // Illegal shape: err next cycle, nothing latched, no segment issued.
    st0 = start_cnt;
    send(2'b11, 16'h1234, od_ill);
    end_q.push_back(2'b01);
    step(1);
    bus.cmd_valid = 1'b0;
    chk("ill_err", bus.err, 1'b1);
    chk("ill_busy", bus.busy, 1'b0);
    chk("ill_opdata", bus.op_opdata, od_circ);
    chk("ill_color", bus.draw_color, 16'h001F);
    chk("ill_ready", bus.cmd_ready, 1'b1);
    step(1);
    chk("ill_err_pulse", bus.err, 1'b0);
    step(2);
    chk("ill_no_start", start_cnt - st0, 0);

    // Watchdog: triangle with no draw_done; err eight cycles after first WAIT cycle.
    st0 = start_cnt; sd0 = sd_cnt;
    send(2'b01, 16'hAAAA, od_wd);
    seg_q.push_back({4'b0001, 1'b0, 2'd0});
    end_q.push_back(2'b01);
    step(1);
    bus.cmd_valid = 1'b0;
    chk("wd_start", bus.draw_start, 1'b1);
    for (int c = 2; c < 10; c++) begin
      step(1);
      chk("wd_err_early", bus.err, 1'b0);
    end
    step(1);
    chk("wd_err", bus.err, 1'b1);
    chk("wd_no_sd", bus.shape_done, 1'b0);
    chk("wd_busy", bus.busy, 1'b0);
    step(1);
    chk("wd_ready", bus.cmd_ready, 1'b1);
    step(2);
    chk("wd_start_count", start_cnt - st0, 1);
    chk("wd_sd_count", sd_cnt - sd0, 0);

    // Reset during WAIT of triangle segment 1.
    send(2'b01, 16'h5555, od_rst);
    seg_q.push_back({4'b0001, 1'b0, 2'd0});
    seg_q.push_back({4'b0010, 1'b0, 2'd1});
    step(1);
    bus.cmd_valid = 1'b0;
    step(2);
    bus.draw_done = 1'b1;
    step(1);
    bus.draw_done = 1'b0;
    step(1);
    chk("rst_pre_seg", bus.seg_idx, 2'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset_vals("mid");
    chk("rst_seg_q", seg_q.size(), 0);

    // Spurious draw_done in IDLE, then in ISSUE of a fresh line command.
    bus.draw_done = 1'b1;
    step(2);
    chk("spur_idle_busy", bus.busy, 1'b0);
    chk("spur_idle_sd", bus.shape_done, 1'b0);
    bus.draw_done = 1'b0;
    send(2'b00, 16'h07E0, od_l2);
    seg_q.push_back({4'b0000, 1'b0, 2'd0});
    end_q.push_back(2'b10);
    step(1);
    bus.cmd_valid = 1'b0;
    bus.draw_done = 1'b1;
    step(1);
    bus.draw_done = 1'b0;
    chk("spur_issue_sd", bus.shape_done, 1'b0);
    chk("spur_issue_busy", bus.busy, 1'b1);
    step(1);
    chk("spur_wait_busy", bus.busy, 1'b1);
    bus.draw_done = 1'b1;
    step(1);
    bus.draw_done = 1'b0;
    chk("l2_sd", bus.shape_done, 1'b1);
    step(1);
    chk("l2_idle", bus.busy, 1'b0);
    chk("l2_opdata", bus.op_opdata, od_l2);

    step(2);
    chk("seg_q_empty", seg_q.size(), 0);
    chk("end_q_empty", end_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shape_sequencer.md
Name: shape_sequencer

Overview:
- Accepts one decoded draw command (shape code, 16-bit colour, 76-bit position field) through a valid/ready handshake.
- Registers the position field, which feeds the location splitter directly.
- Steps the splitter's output select through every segment the shape needs: line = 1, triangle = 3, circle = 1.
- Sequences the downstream line/circle raster engine one segment at a time using a start/done handshake.
- Sits between the opcode decoder and the splitter + raster engine.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles WAIT may last per segment before the command is aborted; must be ≥ 2.
- TO_W, 11: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_shape  in  2  00 line, 01 triangle, 10 circle, 11 illegal
- cmd_color  in  16  5r/6g/5b colour
- cmd_opdata  in  76  position field: [75:57] pos1, [56:38] pos2, [37:19] pos3, [18:0] ignored
- op_opdata  out  76  registered command position field, drives the splitter's opdata input
- output_sel  out  4  splitter select: 0000 LL1, 0001 TL1, 0010 TL2, 0011 TL3, 0100 CA1, 1111 idle (splitter outputs 0)
- draw_color  out  16  registered colour for the raster engine
- draw_start  out  1  one-cycle pulse: begin the segment presented on splitter locations
- draw_circle  out  1  1 = current segment is centre/radius, 0 = line endpoints
- draw_done  in  1  raster engine finished the current segment
- seg_idx  out  2  index of the current segment within the shape (0..2)
- busy  out  1  command in progress (state ≠ IDLE)
- shape_done  out  1  one-cycle pulse: all segments complete
- err  out  1  one-cycle pulse: illegal shape or watchdog abort

Behaviour:
- Reset (rst sampled high at a clock edge) forces the following, overriding any operation in progress. The raster engine is not notified and must be reset alongside.
  - state = IDLE
  - op_opdata = 0, draw_color = 0
  - output_sel = 1111
  - seg_idx = 0
  - draw_start, draw_circle, busy, shape_done, err = 0
  - cmd_ready = 1 in the first cycle after reset
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch opdata, colour and shape; seg_idx = 0.
    - Shape 11: stay IDLE, pulse err next cycle, registers unchanged.
    - Otherwise go to ISSUE.
  - ISSUE (one cycle):
    - output_sel = segment select, per shape/seg_idx: line → 0000; triangle → 0001, 0010, 0011; circle → 0100.
    - draw_start = 1.
    - draw_circle = 1 for circle only.
    - Watchdog cleared.
    - Go to WAIT.
  - WAIT: output_sel, draw_circle, seg_idx held stable; watchdog increments each cycle.
    - On draw_done, if seg_idx < last: seg_idx++, go to ISSUE.
    - On draw_done, if seg_idx is last: go to DONE.
    - Watchdog reaches TIMEOUT_CYCLES without draw_done: pulse err, go to IDLE, no shape_done.
  - DONE (one cycle): shape_done = 1, output_sel = 1111, then IDLE.
- cmd_ready = 0 in ISSUE, WAIT and DONE.
- cmd_valid is ignored when not ready. The upstream holds the command until accepted.
- Timing:
  - Accept at edge 0 → draw_start high in cycle 1.
  - draw_done sampled in cycle k → next draw_start in cycle k+1, or shape_done in cycle k+1.
  - Back-to-back command acceptable in the cycle after DONE.
  - Minimum line command: 4 cycles accept→IDLE, with draw_done in cycle 2.
- draw_done asserted during IDLE, ISSUE or DONE is ignored; only WAIT samples it.
- err and shape_done are never high in the same cycle.
- op_opdata and draw_color change only on acceptance; they hold their value after completion.
- Watchdog saturates and does not wrap.

Test Plan:
- Line: shape 00, opdata[75:57]=19'h12345, [56:38]=19'h00ABC, colour F800.
  - Expect draw_start in cycle 1 with output_sel 0000, draw_circle 0.
  - draw_done in cycle 3 → shape_done in cycle 4, output_sel returns 1111, cmd_ready high in cycle 5.
- Triangle: shape 01, draw_done 2 cycles after each start.
  - Expect draw_start three times with output_sel 0001, 0010, 0011 and seg_idx 0, 1, 2.
  - Exactly one shape_done after the third draw_done.
- Circle: shape 10.
  - Expect output_sel 0100, draw_circle 1, a single draw_start, shape_done after draw_done.
- Illegal shape 11 with cmd_valid.
  - Expect err pulse in the following cycle, no draw_start, busy 0, op_opdata unchanged.
- Watchdog: TIMEOUT_CYCLES=8, triangle, draw_done never asserted.
  - Expect err 8 cycles after the first WAIT cycle, return to IDLE, no shape_done, no second draw_start.
- Reset mid-triangle during WAIT of seg 1, plus spurious draw_done in IDLE/ISSUE.
  - Expect all outputs at reset values next cycle.
  - A draw_done applied in IDLE/ISSUE causes no state change; a fresh line command then completes normally.
